glb_host_arbiter: RTL and testbench

- Two-requester arbiter that shares the global buffer's single host port (write strobe/addr/data, read enable/addr/data) between the host (H) and a streaming/DMA requester (S).
- Accepts valid/ready requests from each side, issues at most one access per cycle onto the global buffer port through registers, and tracks read tags so each read response is returned only to the requester that issued it.
- Sits between the top-level host interface and the global_buffer host_* ports.

---
 rtl/glb_host_arbiter.sv | 183 ++++++++++++++++++
 tb/tb_glb_host_arbiter.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/glb_host_arbiter.sv
// Shares the global buffer host port between the host (H) and stream (S) requesters.
// One registered issue per cycle; a read-tag pipeline steers each response back to its issuer.
module glb_host_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 64,
  parameter int RD_LATENCY = 1,
  parameter int MAX_BURST  = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      h_req_valid,
  output logic                      h_req_ready,
  input  logic                      h_req_write,
  input  logic [ADDR_WIDTH-1:0]     h_req_addr,
  input  logic [DATA_WIDTH-1:0]     h_req_wdata,
  input  logic [DATA_WIDTH/8-1:0]   h_req_strb,
  output logic                      h_rsp_valid,
  output logic [DATA_WIDTH-1:0]     h_rsp_data,
  input  logic                      s_req_valid,
  output logic                      s_req_ready,
  input  logic                      s_req_write,
  input  logic [ADDR_WIDTH-1:0]     s_req_addr,
  input  logic [DATA_WIDTH-1:0]     s_req_wdata,
  input  logic [DATA_WIDTH/8-1:0]   s_req_strb,
  output logic                      s_rsp_valid,
  output logic [DATA_WIDTH-1:0]     s_rsp_data,
  output logic [DATA_WIDTH/8-1:0]   glb_wr_strb,
  output logic [ADDR_WIDTH-1:0]     glb_wr_addr,
  output logic [DATA_WIDTH-1:0]     glb_wr_data,
  output logic                      glb_rd_en,
  output logic [ADDR_WIDTH-1:0]     glb_rd_addr,
  input  logic [DATA_WIDTH-1:0]     glb_rd_data
);
  localparam int STRB_WIDTH = DATA_WIDTH / 8;
  localparam int CNT_WIDTH  = $clog2(MAX_BURST + 1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = CNT_WIDTH'(MAX_BURST);

  typedef enum logic {SIDE_H = 1'b0, SIDE_S = 1'b1} side_e;

  side_e                  r_last_grant;
  logic [CNT_WIDTH-1:0]   r_burst_cnt;

  logic                   w_keep;
  logic                   w_grant_h;
  logic                   w_grant_s;
  logic                   w_xfer;
  side_e                  w_sel;
  logic                   w_write;
  logic [ADDR_WIDTH-1:0]  w_addr;
  logic [DATA_WIDTH-1:0]  w_wdata;
  logic [STRB_WIDTH-1:0]  w_strb;

  logic [STRB_WIDTH-1:0]  r_wr_strb;
  logic [ADDR_WIDTH-1:0]  r_wr_addr;
  logic [DATA_WIDTH-1:0]  r_wr_data;
  logic                   r_rd_en;
  logic [ADDR_WIDTH-1:0]  r_rd_addr;
  side_e                  r_rd_id;

  logic [RD_LATENCY-1:0]  r_tag_vld;
  logic [RD_LATENCY-1:0]  r_tag_s;
  logic                   w_ret_h;
  logic                   w_ret_s;

  logic                   r_h_rsp_valid;
  logic [DATA_WIDTH-1:0]  r_h_rsp_data;
  logic                   r_s_rsp_valid;
  logic [DATA_WIDTH-1:0]  r_s_rsp_data;

  // A zero count means no burst is running, so the waiting side (H after reset) wins a tie.
  always_comb begin
    w_grant_h = 1'b0;
    w_grant_s = 1'b0;
    w_keep    = (r_burst_cnt != '0) && (r_burst_cnt < CNT_MAX);
    if (!reset) begin
      if (h_req_valid && s_req_valid) begin
        if (w_keep) begin
          w_grant_s = (r_last_grant == SIDE_S);
        end else begin
          w_grant_s = (r_last_grant == SIDE_H);
        end
        w_grant_h = ~w_grant_s;
      end else begin
        w_grant_h = h_req_valid;
        w_grant_s = s_req_valid;
      end
    end
  end

  assign h_req_ready = w_grant_h;
  assign s_req_ready = w_grant_s;
  assign w_xfer      = w_grant_h | w_grant_s;
  assign w_sel       = w_grant_s ? SIDE_S : SIDE_H;
  assign w_write     = w_grant_s ? s_req_write : h_req_write;
  assign w_addr      = w_grant_s ? s_req_addr  : h_req_addr;
  assign w_wdata     = w_grant_s ? s_req_wdata : h_req_wdata;
  assign w_strb      = w_grant_s ? s_req_strb  : h_req_strb;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_last_grant <= SIDE_S;
      r_burst_cnt  <= '0;
    end else if (w_xfer) begin
      if (w_sel == r_last_grant) begin
        if (r_burst_cnt != CNT_MAX) begin
          r_burst_cnt <= r_burst_cnt + 1'b1;
        end
      end else begin
        r_last_grant <= w_sel;
        r_burst_cnt  <= CNT_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_strb <= '0;
      r_wr_addr <= '0;
      r_wr_data <= '0;
      r_rd_en   <= 1'b0;
      r_rd_addr <= '0;
      r_rd_id   <= SIDE_H;
    end else begin
      r_wr_strb <= (w_xfer && w_write) ? w_strb : '0;
      r_rd_en   <= w_xfer && !w_write;
      if (w_xfer && w_write) begin
        r_wr_addr <= w_addr;
        r_wr_data <= w_wdata;
      end
      if (w_xfer && !w_write) begin
        r_rd_addr <= w_addr;
        r_rd_id   <= w_sel;
      end
    end
  end

  // Tag stage RD_LATENCY-1 lines up with the cycle glb_rd_data is valid.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_tag_vld <= '0;
      r_tag_s   <= '0;
    end else begin
      r_tag_vld[0] <= r_rd_en;
      r_tag_s[0]   <= (r_rd_id == SIDE_S);
      for (int i = 1; i < RD_LATENCY; i++) begin
        r_tag_vld[i] <= r_tag_vld[i-1];
        r_tag_s[i]   <= r_tag_s[i-1];
      end
    end
  end

  assign w_ret_h = r_tag_vld[RD_LATENCY-1] && !r_tag_s[RD_LATENCY-1];
  assign w_ret_s = r_tag_vld[RD_LATENCY-1] &&  r_tag_s[RD_LATENCY-1];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_h_rsp_valid <= 1'b0;
      r_h_rsp_data  <= '0;
      r_s_rsp_valid <= 1'b0;
      r_s_rsp_data  <= '0;
    end else begin
      r_h_rsp_valid <= w_ret_h;
      r_s_rsp_valid <= w_ret_s;
      if (w_ret_h) begin
        r_h_rsp_data <= glb_rd_data;
      end
      if (w_ret_s) begin
        r_s_rsp_data <= glb_rd_data;
      end
    end
  end

  assign glb_wr_strb = r_wr_strb;
  assign glb_wr_addr = r_wr_addr;
  assign glb_wr_data = r_wr_data;
  assign glb_rd_en   = r_rd_en;
  assign glb_rd_addr = r_rd_addr;
  assign h_rsp_valid = r_h_rsp_valid;
  assign h_rsp_data  = r_h_rsp_data;
  assign s_rsp_valid = r_s_rsp_valid;
  assign s_rsp_data  = r_s_rsp_data;

endmodule

// File: tb/tb_glb_host_arbiter.sv
// Bench for glb_host_arbiter: two instances (MAX_BURST 4 and 1) share one stimulus stream and are
// each checked every cycle against a rule-level model of grants, issue fields and read responses.
module tb_glb_host_arbiter;
  localparam int AW  = 32;
  localparam int DW  = 64;
  localparam int SW  = DW / 8;
  localparam int RDL = 1;

  logic clk = 1'b0;
  logic reset;
  logic mem_init;

  logic          h_req_valid, h_req_write, s_req_valid, s_req_write;
  logic [AW-1:0] h_req_addr, s_req_addr;
  logic [DW-1:0] h_req_wdata, s_req_wdata;
  logic [SW-1:0] h_req_strb, s_req_strb;

  logic          h_req_ready [2];
  logic          s_req_ready [2];
  logic          h_rsp_valid [2];
  logic          s_rsp_valid [2];
  logic [DW-1:0] h_rsp_data  [2];
  logic [DW-1:0] s_rsp_data  [2];
  logic [SW-1:0] glb_wr_strb [2];
  logic [AW-1:0] glb_wr_addr [2];
  logic [DW-1:0] glb_wr_data [2];
  logic          glb_rd_en   [2];
  logic [AW-1:0] glb_rd_addr [2];

  int n_pass  = 0;
  int n_fail  = 0;
  int n_total = 0;
  int cyc     = 0;

  // reference model state, index 0 = MAX_BURST 4, index 1 = MAX_BURST 1
  logic          m_last  [2];
  int            m_burst [2];
  logic [DW-1:0] m_mem   [2][256];
  logic [SW-1:0] e_wr_strb [2];
  logic [AW-1:0] e_wr_addr [2];
  logic [DW-1:0] e_wr_data [2];
  logic          e_rd_en   [2];
  logic [AW-1:0] e_rd_addr [2];
  logic          e_hv [2];
  logic          e_sv [2];
  logic [DW-1:0] e_hd [2];
  logic [DW-1:0] e_sd [2];
  logic          sch_v [2][16];
  logic          sch_s [2][16];
  logic [DW-1:0] sch_d [2][16];

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] pat(input int i);
    return {8'hA5, 24'(i * 7), 32'(i) ^ 32'h5A5A_5A5A};
  endfunction

  for (genvar gi = 0; gi < 2; gi++) begin : g_dut
    logic [DW-1:0] mem [256];
    logic [DW-1:0] rd_q;

    always @(posedge clk) begin
      if (mem_init) begin
        for (int i = 0; i < 256; i++) mem[i] <= pat(i);
      end else begin
        for (int b = 0; b < SW; b++)
          if (glb_wr_strb[gi][b]) mem[glb_wr_addr[gi][7:0]][b*8 +: 8] <= glb_wr_data[gi][b*8 +: 8];
        if (glb_rd_en[gi]) rd_q <= mem[glb_rd_addr[gi][7:0]];
      end
    end

    glb_host_arbiter #(
      .ADDR_WIDTH (AW),
      .DATA_WIDTH (DW),
      .RD_LATENCY (RDL),
      .MAX_BURST  ((gi == 0) ? 4 : 1)
    ) u_dut (
      .clk         (clk),
      .reset       (reset),
      .h_req_valid (h_req_valid),
      .h_req_ready (h_req_ready[gi]),
      .h_req_write (h_req_write),
      .h_req_addr  (h_req_addr),
      .h_req_wdata (h_req_wdata),
      .h_req_strb  (h_req_strb),
      .h_rsp_valid (h_rsp_valid[gi]),
      .h_rsp_data  (h_rsp_data[gi]),
      .s_req_valid (s_req_valid),
      .s_req_ready (s_req_ready[gi]),
      .s_req_write (s_req_write),
      .s_req_addr  (s_req_addr),
      .s_req_wdata (s_req_wdata),
      .s_req_strb  (s_req_strb),
      .s_rsp_valid (s_rsp_valid[gi]),
      .s_rsp_data  (s_rsp_data[gi]),
      .glb_wr_strb (glb_wr_strb[gi]),
      .glb_wr_addr (glb_wr_addr[gi]),
      .glb_wr_data (glb_wr_data[gi]),
      .glb_rd_en   (glb_rd_en[gi]),
      .glb_rd_addr (glb_rd_addr[gi]),
      .glb_rd_data (rd_q)
    );
  end

  task automatic check(input string tag, input int k, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s dut%0d cycle %0d: got %h want %h", tag, k, cyc, obs, exp);
    end
  endtask

  task automatic drive_h(input logic v, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                         input logic [SW-1:0] st);
    h_req_valid = v; h_req_write = w; h_req_addr = a; h_req_wdata = d; h_req_strb = st;
  endtask

  task automatic drive_s(input logic v, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                         input logic [SW-1:0] st);
    s_req_valid = v; s_req_write = w; s_req_addr = a; s_req_wdata = d; s_req_strb = st;
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_last[k] = 1'b1;
      m_burst[k] = 0;
      e_wr_strb[k] = '0; e_wr_addr[k] = '0; e_wr_data[k] = '0;
      e_rd_en[k] = 1'b0; e_rd_addr[k] = '0;
      e_hv[k] = 1'b0; e_sv[k] = 1'b0; e_hd[k] = '0; e_sd[k] = '0;
      for (int i = 0; i < 16; i++) sch_v[k][i] = 1'b0;
    end
  endtask

  task automatic check_zero(input string tag);
    for (int k = 0; k < 2; k++) begin
      check({tag, "_h_ready"}, k, h_req_ready[k], 0);
      check({tag, "_s_ready"}, k, s_req_ready[k], 0);
      check({tag, "_wr_strb"}, k, glb_wr_strb[k], 0);
      check({tag, "_wr_addr"}, k, glb_wr_addr[k], 0);
      check({tag, "_wr_data"}, k, glb_wr_data[k], 0);
      check({tag, "_rd_en"},   k, glb_rd_en[k], 0);
      check({tag, "_rd_addr"}, k, glb_rd_addr[k], 0);
      check({tag, "_h_rsp_v"}, k, h_rsp_valid[k], 0);
      check({tag, "_h_rsp_d"}, k, h_rsp_data[k], 0);
      check({tag, "_s_rsp_v"}, k, s_rsp_valid[k], 0);
      check({tag, "_s_rsp_d"}, k, s_rsp_data[k], 0);
    end
  endtask

  // One clock: check this cycle's outputs, then advance the model by the transfer (if any).
  task automatic step();
    logic gh, gs, wr;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic [SW-1:0] st;
    int mb, slot;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      mb = (k == 0) ? 4 : 1;
      if (h_req_valid && s_req_valid) begin
        // a running burst below its limit keeps the grant, otherwise the waiting side takes over
        if (m_burst[k] > 0 && m_burst[k] < mb) gs = m_last[k];
        else gs = !m_last[k];
        gh = !gs;
      end else begin
        gh = h_req_valid;
        gs = s_req_valid;
      end
      check("h_ready", k, h_req_ready[k], gh);
      check("s_ready", k, s_req_ready[k], gs);
      check("wr_strb", k, glb_wr_strb[k], e_wr_strb[k]);
      check("wr_addr", k, glb_wr_addr[k], e_wr_addr[k]);
      check("wr_data", k, glb_wr_data[k], e_wr_data[k]);
      check("rd_en",   k, glb_rd_en[k], e_rd_en[k]);
      check("rd_addr", k, glb_rd_addr[k], e_rd_addr[k]);
      check("h_rsp_v", k, h_rsp_valid[k], e_hv[k]);
      check("h_rsp_d", k, h_rsp_data[k], e_hd[k]);
      check("s_rsp_v", k, s_rsp_valid[k], e_sv[k]);
      check("s_rsp_d", k, s_rsp_data[k], e_sd[k]);

      e_wr_strb[k] = '0;
      e_rd_en[k]   = 1'b0;
      if (gh || gs) begin
        wr = gs ? s_req_write : h_req_write;
        a  = gs ? s_req_addr  : h_req_addr;
        d  = gs ? s_req_wdata : h_req_wdata;
        st = gs ? s_req_strb  : h_req_strb;
        if (gs == m_last[k]) begin
          m_burst[k] = (m_burst[k] < mb) ? m_burst[k] + 1 : mb;
        end else begin
          m_last[k]  = gs;
          m_burst[k] = 1;
        end
        if (wr) begin
          e_wr_strb[k] = st; e_wr_addr[k] = a; e_wr_data[k] = d;
          for (int b = 0; b < SW; b++) if (st[b]) m_mem[k][a[7:0]][b*8 +: 8] = d[b*8 +: 8];
        end else begin
          e_rd_en[k] = 1'b1; e_rd_addr[k] = a;
          slot = (cyc + RDL + 2) % 16;
          sch_v[k][slot] = 1'b1; sch_s[k][slot] = gs; sch_d[k][slot] = m_mem[k][a[7:0]];
        end
      end
      slot = (cyc + 1) % 16;
      e_hv[k] = 1'b0;
      e_sv[k] = 1'b0;
      if (sch_v[k][slot]) begin
        sch_v[k][slot] = 1'b0;
        if (sch_s[k][slot]) begin e_sv[k] = 1'b1; e_sd[k] = sch_d[k][slot]; end
        else begin e_hv[k] = 1'b1; e_hd[k] = sch_d[k][slot]; end
      end
    end
    @(posedge clk);
    cyc++;
    #1;
  endtask

  initial begin
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < 256; i++) m_mem[k][i] = pat(i);
    drive_h(0, 0, '0, '0, '0);
    drive_s(0, 0, '0, '0, '0);
    reset = 1'b1;
    mem_init = 1'b1;
    @(posedge clk);
    #1;
    mem_init = 1'b0;
    check_zero("por");
    reset = 1'b0;
    model_reset();

    // H write 0x0F then H read of it
    drive_h(1, 1, 32'h0F, 64'h1234_5678, 8'hFF);
    step();
    drive_h(1, 0, 32'h0F, '0, '0);
    step();
    drive_h(0, 0, '0, '0, '0);
    repeat (4) step();

    // both sides reading continuously: bursts alternate
    for (int i = 0; i < 12; i++) begin
      drive_h(1, 0, 32'(i), '0, '0);
      drive_s(1, 0, 32'(8'h40 + i), '0, '0);
      step();
    end
    drive_h(0, 0, '0, '0, '0);
    drive_s(0, 0, '0, '0, '0);
    repeat (4) step();

    // reset with two reads in flight; ready must drop even with valids high
    drive_h(1, 0, 32'h30, '0, '0);
    drive_s(1, 0, 32'h31, '0, '0);
    step();
    step();
    #2 reset = 1'b1;
    #1 check_zero("rst");
    model_reset();
    @(posedge clk);
    cyc++;
    #1 check_zero("rst_hold");
    reset = 1'b0;

    // 6-deep back-to-back reads, S present for the first 4 cycles; first tie goes to H
    for (int i = 0; i < 6; i++) begin
      drive_h(1, 0, 32'(8'h50 + i), '0, '0);
      drive_s(i < 4, 0, 32'(8'h60 + i), '0, '0);
      step();
    end
    drive_h(0, 0, '0, '0, '0);
    drive_s(0, 0, '0, '0, '0);
    repeat (4) step();

    // S partial write then H read of the same address next cycle
    drive_s(1, 1, 32'h20, 64'hAABB_CCDD_1122_3344, 8'h0F);
    step();
    drive_s(0, 0, '0, '0, '0);
    drive_h(1, 0, 32'h20, '0, '0);
    step();
    drive_h(0, 0, '0, '0, '0);
    repeat (4) step();

    // zero-strobe write is a no-op
    drive_h(1, 1, 32'h20, 64'hDEAD_BEEF_DEAD_BEEF, 8'h00);
    step();
    drive_h(1, 0, 32'h20, '0, '0);
    step();
    drive_h(0, 0, '0, '0, '0);
    repeat (4) step();

    // random traffic on a small address window for read-after-write collisions
    for (int n = 0; n < 400; n++) begin
      drive_h($urandom_range(0, 9) < 6, $urandom_range(0, 9) < 4,
              {24'($urandom), 8'($urandom_range(0, 15))}, {$urandom, $urandom},
              ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom));
      drive_s($urandom_range(0, 9) < 6, $urandom_range(0, 9) < 4,
              {24'($urandom), 8'($urandom_range(0, 15))}, {$urandom, $urandom},
              ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom));
      step();
    end
    drive_h(0, 0, '0, '0, '0);
    drive_s(0, 0, '0, '0, '0);
    repeat (5) step();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
